// File: rtl/instruction_decoder_fifo_pkg.sv
// Shared decoder constants: opcode encodings and the LSB of the register/address field.
package instruction_decoder_fifo_pkg;

    localparam int FIELD_LSB = 4;

    localparam int OP_WBR    = 0;
    localparam int OP_WSM    = 1;
    localparam int OP_WOF    = 2;
    localparam int OP_STATUS = 3;

endpackage

// File: rtl/instruction_decoder_fifo_sync_fifo.sv
// Single-clock FIFO with synchronous reset and power-of-two pointer wrap.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instruction_decoder_fifo.sv
// Buffered instruction decoder: host writes are queued, the queue head is decoded
// and handed to the video control unit through a registered valid/ready slice.
module instruction_decoder_fifo
    import instruction_decoder_fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int OPCODE_W = 4,
    parameter int REG_W    = 5,
    parameter int ADDR_W   = 14,
    parameter int NUM_OPS  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            dataA,
    input  logic [31:0]            dataB,
    input  logic                   clk_en,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPCODE_W-1:0]    out_opcode,
    output logic [REG_W-1:0]       out_register,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [31:0]            out_data,
    output logic                   overflow,
    output logic                   illegal_op,
    input  logic                   clear_flags
);

    logic                in_legal;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [63:0]         head;
    logic [31:0]         head_a;
    logic [31:0]         head_b;
    logic [OPCODE_W-1:0] dec_opcode;
    logic [REG_W-1:0]    dec_register;
    logic [ADDR_W-1:0]   dec_addr;
    logic [31:0]         dec_data;
    logic                unused_head;

    assign in_legal = (32'(dataA[OPCODE_W-1:0]) < NUM_OPS);
    assign push     = clk_en && !fifo_full && in_legal;
    assign pop      = (!out_valid || out_ready) && !fifo_empty;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({dataA, dataB}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_a = head[63:32];
    assign head_b = head[31:0];
    // Upper bits of word A carry no field; fold them so they are visibly consumed.
    assign unused_head = ^head_a;

    // Field decode of the queue head; only legal opcodes ever reach the queue.
    always_comb begin
        dec_opcode   = head_a[OPCODE_W-1:0];
        dec_register = '0;
        dec_addr     = '0;
        dec_data     = '0;
        if (dec_opcode == OPCODE_W'(OP_WBR) || dec_opcode == OPCODE_W'(OP_WOF)) begin
            dec_register = head_a[FIELD_LSB +: REG_W];
            dec_data     = head_b;
        end else if (dec_opcode == OPCODE_W'(OP_WSM)) begin
            dec_addr = head_a[FIELD_LSB +: ADDR_W];
            dec_data = head_b;
        end
    end

    // Output slice: refills whenever it is empty or being accepted, holds under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_opcode   <= '0;
            out_register <= '0;
            out_addr     <= '0;
            out_data     <= '0;
        end else if (pop) begin
            out_valid    <= 1'b1;
            out_opcode   <= dec_opcode;
            out_register <= dec_register;
            out_addr     <= dec_addr;
            out_data     <= dec_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            if (clear_flags)            overflow   <= 1'b0;
            if (clk_en && fifo_full)    overflow   <= 1'b1;
            if (clear_flags)            illegal_op <= 1'b0;
            if (clk_en && !in_legal)    illegal_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_decoder_fifo.sv
module tb_instruction_decoder_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        clk_en;
    logic        fifo_full;
    logic [3:0]  fifo_count;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [4:0]  out_register;
    logic [13:0] out_addr;
    logic [31:0] out_data;
    logic        overflow;
    logic        illegal_op;
    logic        clear_flags;
    logic [54:0] cur;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign cur = {out_opcode, out_register, out_addr, out_data};

    instruction_decoder_fifo #(
        .DEPTH(8), .OPCODE_W(4), .REG_W(5), .ADDR_W(14), .NUM_OPS(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dataA        (dataA),
        .dataB        (dataB),
        .clk_en       (clk_en),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_register (out_register),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .overflow     (overflow),
        .illegal_op   (illegal_op),
        .clear_flags  (clear_flags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [54:0] model(input logic [31:0] a, input logic [31:0] b);
        case (a[3:0])
            4'd0, 4'd2: model = {a[3:0], a[8:4], 14'h0, b};
            4'd1:       model = {a[3:0], 5'h0, a[17:4], b};
            default:    model = {a[3:0], 5'h0, 14'h0, 32'h0};
        endcase
    endfunction

    initial begin
        logic [54:0] exp_q[$];
        logic [54:0] held;
        logic        stalled;
        logic [31:0] a;
        int          sent;
        int          got;

        reset = 1'b1; dataA = '0; dataB = '0; clk_en = 1'b0;
        out_ready = 1'b1; clear_flags = 1'b0;
        #2;
        step(); step();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_fields", cur, 0);

        // single WBR: visible one edge after the push, valid for one cycle
        dataA = 32'h0000_0050; dataB = 32'h0012_0034; clk_en = 1'b1;
        step();
        clk_en = 1'b0;
        chk("wbr_count_after_push", fifo_count, 1);
        chk("wbr_not_yet_valid", out_valid, 0);
        step();
        chk("wbr_valid", out_valid, 1);
        chk("wbr_fields", cur, {4'd0, 5'd5, 14'h0, 32'h0012_0034});
        chk("wbr_count_after_pop", fifo_count, 0);
        step();
        chk("wbr_valid_drop", out_valid, 0);

        // WSM address slice, register forced to zero
        dataA = 32'h0001_2341; dataB = 32'hDEAD_BEEF; clk_en = 1'b1;
        step();
        clk_en = 1'b0;
        step();
        chk("wsm_fields", cur, {4'd1, 5'd0, 14'h1234, 32'hDEAD_BEEF});
        step();

        // back-to-back WOF then STATUS
        dataA = 32'h0000_00F2; dataB = 32'h0000_1111; clk_en = 1'b1;
        step();
        dataA = 32'h0000_0FF3; dataB = 32'h0000_0055;
        step();
        clk_en = 1'b0;
        chk("wof_fields", cur, {4'd2, 5'h0F, 14'h0, 32'h0000_1111});
        step();
        chk("status_valid", out_valid, 1);
        chk("status_fields", cur, {4'd3, 5'd0, 14'h0, 32'h0});
        step();
        chk("b2b_drain", out_valid, 0);

        // fill with output stalled: slice + DEPTH entries, the 10th push is dropped
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dataA = 32'(i) << 4; dataB = 32'hA000_0000 + 32'(i); clk_en = 1'b1;
            step();
            if (i == 7) chk("fill_not_full", fifo_full, 0);
            if (i == 8) chk("fill_full", fifo_full, 1);
        end
        clk_en = 1'b0;
        chk("fill_count", fifo_count, 8);
        chk("fill_overflow", overflow, 1);

        // push while full in the same cycle as a pop is still rejected
        out_ready = 1'b1;
        dataA = 32'h0000_0BA0; dataB = 32'h0000_0BAD; clk_en = 1'b1;
        for (int j = 0; j < 9; j++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_order", cur, {4'd0, 5'(j), 14'h0, 32'hA000_0000 + 32'(j)});
            step();
            clk_en = 1'b0;
            if (j == 0) chk("full_pop_push_count", fifo_count, 7);
        end
        chk("drain_empty", out_valid, 0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("overflow_cleared", overflow, 0);

        // illegal opcode
        dataA = 32'h0000_000F; dataB = 32'h1234_5678; clk_en = 1'b1;
        step();
        clk_en = 1'b0;
        chk("illegal_flag", illegal_op, 1);
        chk("illegal_count", fifo_count, 0);
        step();
        chk("illegal_no_output", out_valid, 0);
        clear_flags = 1'b1;
        step();
        chk("illegal_cleared", illegal_op, 0);
        dataA = 32'h0000_0004; clk_en = 1'b1;
        step();
        clear_flags = 1'b0; clk_en = 1'b0;
        chk("illegal_set_wins", illegal_op, 1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("illegal_cleared2", illegal_op, 0);

        // randomized stream with stalls against a queue model
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 20 && !fifo_full && $urandom_range(0, 1) == 1) begin
                a = $urandom;
                a[3:0] = 4'($urandom_range(0, 3));
                dataA = a; dataB = $urandom; clk_en = 1'b1;
                exp_q.push_back(model(dataA, dataB));
                sent++;
            end else begin
                clk_en = 1'b0;
            end
            stalled = out_valid && !out_ready;
            held = cur;
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) begin
                    chk("stream_order", cur, exp_q.pop_front());
                end else begin
                    miscompares++;
                    $error("FAIL stream_extra: observed %0h expected none", cur);
                end
                got++;
            end
            step();
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", cur, held);
            end
        end
        clk_en = 1'b0;
        chk("stream_received", got, 20);
        out_ready = 1'b1;
        step(); step();

        // reset with three queued and the slice occupied, also ignoring a strobe
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dataA = (32'(i + 1) << 4) | 32'h2; dataB = 32'(i); clk_en = 1'b1;
            step();
        end
        clk_en = 1'b0;
        chk("pre_reset_count", fifo_count, 3);
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b1; clk_en = 1'b1; dataA = 32'h0000_0010;
        step();
        reset = 1'b0; clk_en = 1'b0;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_fields", cur, 0);
        chk("mid_reset_count", fifo_count, 0);
        out_ready = 1'b1;
        dataA = 32'h0000_0070; dataB = 32'h0000_0077; clk_en = 1'b1;
        step();
        clk_en = 1'b0;
        step();
        chk("post_reset_fields", cur, {4'd0, 5'd7, 14'h0, 32'h0000_0077});
        chk("post_reset_valid", out_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
